uart_tx_frame: RTL and testbench

- Parametrised successor transmitter for the board UART link.
- Configurable data width, parity mode, stop-bit count and input FIFO depth.
- Accepts bytes over a valid/ready handshake and buffers them in an internal FIFO.
- Sends frames back-to-back with no idle gap; also supports a host-driven line break.

---
 rtl/uart_tx_frame.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with input FIFO,
// back-to-back framing and host-driven line break.
module uart_tx_frame #(
  parameter int CLOCK_FREQUENCY = 12_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_tx_valid,
  input  logic [DATA_BITS-1:0]          i_tx_data,
  output logic                          o_tx_ready,
  input  logic                          i_break,
  output logic                          o_uart_tx,
  output logic                          o_uart_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int DIV = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CW  = ($clog2(DIV) < 1) ? 1 : $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int NW  = AW + 1;

  localparam logic [CW-1:0] CNT_TOP = CW'(DIV - 1);
  localparam logic [3:0]    LAST_D  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_S  = 4'(STOP_BITS - 1);
  localparam logic [NW-1:0] FULL    = NW'(FIFO_DEPTH);

  if (DIV < 2) begin : g_div_chk
    $error("uart_tx_frame: CLOCK_FREQUENCY/BAUD_RATE must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_dbits_chk
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_par_chk
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 3) begin : g_stop_chk
    $error("uart_tx_frame: STOP_BITS must be 1..3");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fifo_chk
    $error("uart_tx_frame: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [NW-1:0]        count;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  state_t               state;
  logic [CW-1:0]        baud;
  logic [3:0]           bitn;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 bit_end;
  logic                 line;

  assign o_tx_ready   = (count != FULL);
  assign o_fifo_count = count;
  assign o_uart_busy  = (state != S_IDLE) || (count != '0);
  assign push         = i_tx_valid && o_tx_ready;
  assign head         = mem[rd_ptr];
  assign bit_end      = (baud == '0);

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_tx_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  // Break wins over queued data, both from IDLE and at the end of STOP.
  always_comb begin
    pop = 1'b0;
    unique case (state)
      S_IDLE: pop = !i_break && (count != '0);
      S_STOP: pop = bit_end && (bitn == LAST_S) && !i_break && (count != '0);
      default: pop = 1'b0;
    endcase
  end

  always_comb begin
    line = 1'b1;
    unique case (state)
      S_START:  line = 1'b0;
      S_DATA:   line = shreg[0];
      S_PARITY: line = par_bit;
      S_BREAK:  line = 1'b0;
      default:  line = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      baud      <= '0;
      bitn      <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      o_uart_tx <= 1'b1;
    end else begin
      o_uart_tx <= line;
      if (state != S_IDLE) baud <= bit_end ? CNT_TOP : baud - CW'(1);
      unique case (state)
        S_IDLE: begin
          if (i_break) begin
            state <= S_BREAK;
            baud  <= CNT_TOP;
          end else if (pop) begin
            shreg   <= head;
            par_bit <= (^head) ^ (PARITY == 1);
            state   <= S_START;
            baud    <= CNT_TOP;
          end
        end
        S_START: begin
          if (bit_end) begin
            state <= S_DATA;
            bitn  <= '0;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shreg <= shreg >> 1;
            if (bitn == LAST_D) begin
              bitn  <= '0;
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bitn <= bitn + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state <= S_STOP;
            bitn  <= '0;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (bitn != LAST_S) begin
              bitn <= bitn + 4'd1;
            end else if (i_break) begin
              state <= S_BREAK;
            end else if (pop) begin
              shreg   <= head;
              par_bit <= (^head) ^ (PARITY == 1);
              state   <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_BREAK: begin
          // Counter parks at zero once the minimum break length is met.
          if (bit_end) begin
            if (i_break) begin
              baud <= '0;
            end else begin
              state <= S_STOP;
              bitn  <= '0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed checks of uart_tx_frame at DIV=10
// for 8N1, 7E2 and 8O1 configurations.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] vld = '0;
  logic [2:0] brk = '0;
  logic [7:0] dat0 = '0;
  logic [6:0] dat1 = '0;
  logic [7:0] dat2 = '0;
  logic [2:0] tx;
  logic [2:0] rdy;
  logic [2:0] busy;
  logic [2:0] cnt0;
  logic [2:0] cnt1;
  logic [2:0] cnt2;

  int   n_err = 0;
  int   n_chk = 0;
  int   full_seen = 0;
  int   rdy_bad = 0;
  logic busy_last;

  always #5 clk = ~clk;

  uart_tx_frame #(
    .CLOCK_FREQUENCY(1_000_000), .BAUD_RATE(100_000)
  ) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_valid(vld[0]),
    .i_tx_data(dat0), .o_tx_ready(rdy[0]), .i_break(brk[0]),
    .o_uart_tx(tx[0]), .o_uart_busy(busy[0]), .o_fifo_count(cnt0)
  );

  uart_tx_frame #(
    .CLOCK_FREQUENCY(1_000_000), .BAUD_RATE(100_000),
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
  ) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_valid(vld[1]),
    .i_tx_data(dat1), .o_tx_ready(rdy[1]), .i_break(brk[1]),
    .o_uart_tx(tx[1]), .o_uart_busy(busy[1]), .o_fifo_count(cnt1)
  );

  uart_tx_frame #(
    .CLOCK_FREQUENCY(1_000_000), .BAUD_RATE(100_000),
    .PARITY(1)
  ) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_valid(vld[2]),
    .i_tx_data(dat2), .o_tx_ready(rdy[2]), .i_break(brk[2]),
    .o_uart_tx(tx[2]), .o_uart_busy(busy[2]), .o_fifo_count(cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input int idx, input logic [7:0] d);
    if (idx == 0) dat0 = d;
    else if (idx == 1) dat1 = d[6:0];
    else dat2 = d;
    vld[idx] = 1'b1;
    @(negedge clk);
    vld[idx] = 1'b0;
  endtask

  task automatic wait_start(input int idx);
    int n = 0;
    while (tx[idx] !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", {31'b0, tx[idx]}, 32'd0);
  endtask

  // Current negedge is the first sample of the start bit.
  task automatic rx_frame(input string tag, input int idx,
                          input int nbits, input logic [15:0] exp);
    logic [9:0] v;
    for (int b = 0; b < nbits; b++) begin
      for (int k = 0; k < 10; k++) begin
        if (!(b == 0 && k == 0)) begin
          busy_last = busy[idx];
          @(negedge clk);
        end
        v[k] = tx[idx];
      end
      check($sformatf("%s_bit%0d", tag, b), {22'b0, v}, {22'b0, {10{exp[b]}}});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [24:0] lowv;
    logic [9:0]  hv;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, tx[0]}, 32'd1);
    check("rst_ready", {31'b0, rdy[0]}, 32'd1);
    check("rst_busy", {31'b0, busy[0]}, 32'd0);
    check("rst_count", {29'b0, cnt0}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 0xA5, latency and busy fall
    send(0, 8'hA5);
    check("lat_e0", {31'b0, tx[0]}, 32'd1);
    @(negedge clk);
    check("lat_e1", {31'b0, tx[0]}, 32'd1);
    @(negedge clk);
    check("lat_e2", {31'b0, tx[0]}, 32'd0);
    rx_frame("a5", 0, 10, 16'h034A);
    check("busy_pre_fall", {31'b0, busy_last}, 32'd1);
    check("busy_fall", {31'b0, busy[0]}, 32'd0);

    // 7E2 0x53
    send(1, 8'h53);
    wait_start(1);
    rx_frame("e53", 1, 11, {5'b0, 2'b11, 1'b0, 7'h53, 1'b0});
    check("e53_busy_end", {31'b0, busy[1]}, 32'd0);

    // 8O1 0x00 and 0x01
    send(2, 8'h00);
    wait_start(2);
    rx_frame("o00", 2, 11, {5'b0, 2'b11, 8'h00, 1'b0});
    send(2, 8'h01);
    wait_start(2);
    rx_frame("o01", 2, 11, {5'b0, 2'b10, 8'h01, 1'b0});
    check("o01_busy_end", {31'b0, busy[2]}, 32'd0);

    // FIFO fill with 0x10..0x15, back-to-back frames
    repeat (3) @(negedge clk);
    fork
      begin : drv
        int   i;
        int   g;
        logic acc;
        i = 0;
        g = 0;
        dat0 = 8'h10;
        vld[0] = 1'b1;
        while (i < 6 && g < 3000) begin
          acc = rdy[0];
          if (cnt0 == 3'd4) full_seen++;
          if (rdy[0] != (cnt0 != 3'd4)) rdy_bad++;
          @(negedge clk);
          g++;
          if (acc) begin
            i++;
            dat0 = 8'(8'h10 + i);
          end
        end
        vld[0] = 1'b0;
        check("fifo_all_accepted", i, 6);
      end
      begin : rcv
        wait_start(0);
        for (int j = 0; j < 6; j++) begin
          if (j > 0) @(negedge clk);
          rx_frame($sformatf("q%0d", j), 0, 10,
                   {6'b0, 1'b1, 8'(8'h10 + j), 1'b0});
        end
      end
    join
    check("fifo_full_seen", {31'b0, full_seen > 0}, 32'd1);
    check("fifo_ready_rule", rdy_bad, 0);
    check("fifo_drained_cnt", {29'b0, cnt0}, 32'd0);
    check("fifo_drained_busy", {31'b0, busy[0]}, 32'd0);

    // Break during 0x3C with 0x7E queued
    repeat (3) @(negedge clk);
    send(0, 8'h3C);
    send(0, 8'h7E);
    brk[0] = 1'b1;
    wait_start(0);
    rx_frame("b3c", 0, 10, {6'b0, 1'b1, 8'h3C, 1'b0});
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      lowv[k] = tx[0];
    end
    check("brk_low", {7'b0, lowv}, 32'd0);
    check("brk_busy", {31'b0, busy[0]}, 32'd1);
    brk[0] = 1'b0;
    @(negedge clk);
    check("brk_tail", {31'b0, tx[0]}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      hv[k] = tx[0];
    end
    check("brk_stop", {22'b0, hv}, 32'h3FF);
    @(negedge clk);
    rx_frame("b7e", 0, 10, {6'b0, 1'b1, 8'h7E, 1'b0});

    // Reset mid data bit with two bytes queued
    repeat (3) @(negedge clk);
    send(0, 8'h11);
    send(0, 8'h22);
    send(0, 8'h33);
    wait_start(0);
    repeat (25) @(negedge clk);
    check("pre_rst_tx", {31'b0, tx[0]}, 32'd0);
    check("pre_rst_cnt", {29'b0, cnt0}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", {31'b0, tx[0]}, 32'd1);
    check("mid_rst_cnt", {29'b0, cnt0}, 32'd0);
    check("mid_rst_busy", {31'b0, busy[0]}, 32'd0);
    check("mid_rst_ready", {31'b0, rdy[0]}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 8'h5A);
    wait_start(0);
    rx_frame("r5a", 0, 10, {6'b0, 1'b1, 8'h5A, 1'b0});
    check("r5a_busy_end", {31'b0, busy[0]}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
